// File: rtl/aes_inv_key_scheduler_if.sv
`default_nettype none
// ============================================================================
// aes_inv_key_scheduler_if - start/key request and round-key stream bundle
// Revision 1.0
// ============================================================================
interface aes_inv_key_scheduler_if #(
  parameter int NK = 4
);
  logic              start;
  logic [32*NK-1:0]  key_in;
  logic              busy;
  logic              rk_valid;
  logic              rk_ready;
  logic [127:0]      rk_data;
  logic [3:0]        rk_round;
  logic              rk_last;
  logic              done;

  // master: requester and round-key consumer; slave: the scheduler
  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_data, rk_round, rk_last, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_data, rk_round, rk_last, done
  );
endinterface
`default_nettype wire

// File: rtl/aes_inv_key_scheduler.sv
`default_nettype none
// ============================================================================
// aes_inv_key_scheduler - word-serial AES key expansion, round keys streamed NR..0
// Revision 1.0
// ============================================================================
module aes_inv_key_scheduler #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  aes_inv_key_scheduler_if.slave   bus
);
  localparam int NW = 4 * (NR + 1);
  localparam int IW = $clog2(NW);
  localparam logic [IW-1:0] LAST_W = IW'(NW - 1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t          r_state;
  logic [31:0]     r_w [NW];
  logic [IW-1:0]   r_i;
  logic [2:0]      r_mod;
  logic [7:0]      r_rcon;
  logic            r_busy;
  logic            r_valid;
  logic            r_last;
  logic            r_done;
  logic [127:0]    r_data;
  logic [3:0]      r_round;

  logic [31:0]     w_prev;
  logic [31:0]     w_sub_in;
  logic [31:0]     w_sub;
  logic [31:0]     w_temp;
  logic [31:0]     w_new;
  logic [IW-1:0]   w_base;
  logic            w_xfer;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*(255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // r_mod tracks i mod NK so no divider is needed for the non-power-of-two NK=6 case
  assign w_prev   = r_w[r_i - IW'(1)];
  assign w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign w_sub[8*g +: 8] = sbox(w_sub_in[8*g +: 8]);
  end

  always_comb begin
    w_temp = w_prev;
    if (r_mod == 3'd0) begin
      w_temp = w_sub ^ {r_rcon, 24'h0};
    end else if ((NK > 6) && (r_mod == 3'd4)) begin
      w_temp = w_sub;
    end
  end

  assign w_new  = r_w[r_i - IW'(NK)] ^ w_temp;
  assign w_base = IW'({r_round - 4'd1, 2'b00});
  assign w_xfer = r_valid && bus.rk_ready;

  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && bus.start) begin
      for (int k = 0; k < NK; k++) begin
        r_w[k] <= bus.key_in[32*(NK-1-k) +: 32];
      end
    end else if (r_state == S_EXPAND) begin
      r_w[r_i] <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
      r_round <= '0;
      r_i     <= IW'(NK);
      r_mod   <= 3'd0;
      r_rcon  <= 8'h01;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_EXPAND;
            r_busy  <= 1'b1;
            r_i     <= IW'(NK);
            r_mod   <= 3'd0;
            r_rcon  <= 8'h01;
          end
        end
        S_EXPAND: begin
          r_i   <= r_i + IW'(1);
          r_mod <= (r_mod == 3'(NK - 1)) ? 3'd0 : r_mod + 3'd1;
          if (r_mod == 3'd0) begin
            r_rcon <= xtime(r_rcon);
          end
          // the last word is still in flight, so take it straight from the datapath
          if (r_i == LAST_W) begin
            r_state <= S_STREAM;
            r_valid <= 1'b1;
            r_round <= 4'(NR);
            r_last  <= 1'b0;
            r_data  <= {r_w[NW-4], r_w[NW-3], r_w[NW-2], w_new};
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (r_round == 4'd0) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_round <= r_round - 4'd1;
              r_last  <= (r_round == 4'd1);
              r_data  <= {r_w[w_base], r_w[w_base + IW'(1)],
                          r_w[w_base + IW'(2)], r_w[w_base + IW'(3)]};
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.rk_valid = r_valid;
  assign bus.rk_data  = r_data;
  assign bus.rk_round = r_round;
  assign bus.rk_last  = r_last;
  assign bus.done     = r_done;
endmodule
`default_nettype wire

// File: tb/tb_aes_inv_key_scheduler.sv
`default_nettype none
// ============================================================================
// tb_aes_inv_key_scheduler - scoreboard bench over AES-128/192/256 instances
// Revision 1.0
// ============================================================================
module tb_aes_inv_key_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_inv_key_scheduler_if #(.NK(4)) bus4 ();
  aes_inv_key_scheduler_if #(.NK(6)) bus6 ();
  aes_inv_key_scheduler_if #(.NK(8)) bus8 ();

  aes_inv_key_scheduler #(.NK(4), .NR(10)) u_dut128 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  aes_inv_key_scheduler #(.NK(6), .NR(12)) u_dut192 (.clk(clk), .rst_n(rst_n), .bus(bus6));
  aes_inv_key_scheduler #(.NK(8), .NR(14)) u_dut256 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int           sel;
  logic         start;
  logic         ready;
  logic [255:0] key;

  assign bus4.start    = start && (sel == 0);
  assign bus6.start    = start && (sel == 1);
  assign bus8.start    = start && (sel == 2);
  assign bus4.key_in   = key[255 -: 128];
  assign bus6.key_in   = key[255 -: 192];
  assign bus8.key_in   = key;
  assign bus4.rk_ready = ready;
  assign bus6.rk_ready = ready;
  assign bus8.rk_ready = ready;

  logic         busy, valid, last, done;
  logic [127:0] data;
  logic [3:0]   round;

  always_comb begin
    case (sel)
      1: begin
        busy = bus6.busy; valid = bus6.rk_valid; last = bus6.rk_last;
        done = bus6.done; data = bus6.rk_data;   round = bus6.rk_round;
      end
      2: begin
        busy = bus8.busy; valid = bus8.rk_valid; last = bus8.rk_last;
        done = bus8.done; data = bus8.rk_data;   round = bus8.rk_round;
      end
      default: begin
        busy = bus4.busy; valid = bus4.rk_valid; last = bus4.rk_last;
        done = bus4.done; data = bus4.rk_data;   round = bus4.rk_round;
      end
    endcase
  end

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          errors;
  logic [7:0]  sbox_m [256];
  logic [31:0] mw [60];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box derived from the field inverse and affine map rather than a table
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(a), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] k, input int nk, input int nr);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < nk; i++) mw[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  // Called at a negedge; returns at the negedge showing done (or after an abort).
  task automatic run(input int s, input logic [255:0] k, input int stall_pct,
                     input bit inject, input int abort_round,
                     input logic [127:0] first_exp, input bit has_r1,
                     input logic [127:0] r1_exp);
    int nk = 4 + 2*s;
    int nr = nk + 6;
    int n, cycles, xfers;
    bit stalled;
    logic [127:0] hold_d;
    logic [3:0]   hold_r;
    exp_t e;
    model_expand(k, nk, nr);
    for (int r = nr; r >= 0; r--)
      sb.push_back({4'(r), mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
    sel = s; key = k; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_low_after_start", done, 0);
    n = 0;
    while (!valid && n < 200) begin
      if (inject && n == 10) begin start = 1'b1; key = ~k; end
      else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", n, 4*(nr+1) - nk);
    if (!valid) begin sb.delete(); return; end
    xfers = 0; cycles = 0; stalled = 0;
    while (busy && cycles < 400) begin
      if (abort_round >= 0 && valid && round == 4'(abort_round)) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        check("abort_data", data, 0);
        check("abort_round", round, 0);
        check("abort_last_done", {last, done}, 0);
        sb.delete();
        return;
      end
      if (stalled) begin
        check("hold_data", data, hold_d);
        check("hold_round", round, hold_r);
      end
      start = inject && (xfers == 3);
      ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
      if (valid && ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rk_round", round, e.rnd);
          check("rk_data", data, e.key);
          check("rk_last", last, (e.rnd == 4'd0));
          if (xfers == 0) check("first_vector", data, first_exp);
          if (has_r1 && e.rnd == 4'd1) check("round1_vector", data, r1_exp);
          if (e.rnd == 4'd0) check("round0_is_key", data, k[255 -: 128]);
        end
        xfers++;
        stalled = 0;
      end else if (valid) begin
        stalled = 1;
        hold_d = data;
        hold_r = round;
      end else begin
        check("valid_dropped_while_busy", valid, 1);
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check("done_pulse", done, 1);
    check("valid_after_done", valid, 0);
    check("last_after_done", last, 0);
    check("transfers", xfers, nr + 1);
    check("sb_drained", sb.size(), 0);
    if (stall_pct == 0) check("stream_cycles", cycles, nr + 1);
    sb.delete();
  endtask

  initial begin
    checks = 0; errors = 0;
    sel = 0; start = 1'b0; ready = 1'b0; key = '0; rst_n = 1'b0;
    build_sbox();
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_valid", valid, 0);
    check("reset_data", data, 0);
    check("reset_round", round, 0);
    check("reset_last_done", {last, done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, K128, 0, 0, -1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1,
        128'ha0fafe1788542cb123a339392a6c7605);
    // next start lands in the done cycle
    run(0, K128, 0, 0, -1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, '0);
    repeat (2) @(negedge clk);
    run(1, K192, 0, 0, -1, 128'he98ba06f448c773c8ecc720401002202, 0, '0);
    repeat (2) @(negedge clk);
    run(2, K256, 0, 0, -1, 128'hfe4890d1e6188d0b046df344706c631e, 0, '0);
    repeat (2) @(negedge clk);
    run(0, K128, 45, 0, -1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, '0);
    run(2, K256, 60, 0, -1, 128'hfe4890d1e6188d0b046df344706c631e, 0, '0);
    repeat (2) @(negedge clk);
    run(0, K128, 0, 1, -1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, '0);
    repeat (2) @(negedge clk);
    run(1, K192, 30, 1, -1, 128'he98ba06f448c773c8ecc720401002202, 0, '0);
    repeat (2) @(negedge clk);
    run(0, K128, 0, 0, 5, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, '0);
    run(0, K128, 0, 0, -1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1,
        128'ha0fafe1788542cb123a339392a6c7605);
    repeat (2) @(negedge clk);
    check("done_single_cycle", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
